// File: rtl/my_struct_package.sv
// my_struct_package: shared cache line, MESI, request-op and FSM types
// plus the default cache geometry used by cache_set_array and way_select.
package my_struct_package;

    localparam int DEF_SETS    = 16384;
    localparam int DEF_WAYS    = 8;
    localparam int DEF_TAG_W   = 12;
    localparam int LRU_FIELD_W = $clog2(DEF_WAYS);
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef struct packed {
        logic [DEF_TAG_W-1:0]   tag;
        logic [LRU_FIELD_W-1:0] lru;
        mesi_t                  mesi_bits;
        logic [DATA_W-1:0]      data;
    } cache_line_t;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_WRITE  = 2'd1,
        OP_CLEAR  = 2'd2
    } cache_op_t;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/cache_set_array_way_select.sv
// way_select: combinational hit and victim selection over one set.
// Ports: lines (WAYS cache lines), tag (compare tag) -> hit, hit_way
// (lowest hitting way, 0 on miss), victim_way (lowest Invalid way, else the
// way whose LRU is WAYS-1, else way 0).
module way_select
    import my_struct_package::*;
#(
    parameter int WAYS  = DEF_WAYS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int LRU_W = $clog2(WAYS)
) (
    input  cache_line_t [WAYS-1:0] lines,
    input  logic [TAG_W-1:0]       tag,
    output logic                   hit,
    output logic [LRU_W-1:0]       hit_way,
    output logic [LRU_W-1:0]       victim_way
);

    logic             inv_found;
    logic [LRU_W-1:0] inv_way;
    logic [LRU_W-1:0] lru_way;

    // Scanning downwards lets the lowest-numbered match overwrite the rest.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lines[w].mesi_bits != MESI_I && lines[w].tag == tag) begin
                hit     = 1'b1;
                hit_way = LRU_W'(w);
            end
            if (lines[w].mesi_bits == MESI_I) begin
                inv_found = 1'b1;
                inv_way   = LRU_W'(w);
            end
            if (lines[w].lru == LRU_FIELD_W'(WAYS - 1))
                lru_way = LRU_W'(w);
        end
        // A corrupt LRU state with no Invalid way leaves lru_way at way 0.
        victim_way = inv_found ? inv_way : lru_way;
    end

endmodule

// File: rtl/cache_set_array.sv
// cache_set_array: SETS x WAYS cache line store with a ready/valid request
// port, registered lookup responses and an invalidate sweep.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_op/req_index/
// req_tag/wr_lines request; rsp_valid/rsp_lines/rsp_hit/rsp_hit_way/
// rsp_victim_way lookup response; init_busy high while sweeping.
module cache_set_array
    import my_struct_package::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WAYS  = DEF_WAYS,
    parameter int TAG_W = DEF_TAG_W,
    localparam int INDEX_W = $clog2(SETS),
    localparam int LRU_W   = $clog2(WAYS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  cache_op_t              req_op,
    input  logic [INDEX_W-1:0]     req_index,
    input  logic [TAG_W-1:0]       req_tag,
    input  cache_line_t [WAYS-1:0] wr_lines,
    output logic                   rsp_valid,
    output cache_line_t [WAYS-1:0] rsp_lines,
    output logic                   rsp_hit,
    output logic [LRU_W-1:0]       rsp_hit_way,
    output logic [LRU_W-1:0]       rsp_victim_way,
    output logic                   init_busy
);

    cache_line_t [WAYS-1:0] mem [SETS];

    state_t                 state_q, state_d;
    logic [INDEX_W-1:0]     sweep_idx_q, sweep_idx_d;
    logic                   rd_valid_q, rd_valid_d;
    cache_line_t [WAYS-1:0] rd_lines_q, rd_lines_d;
    logic [TAG_W-1:0]       rd_tag_q, rd_tag_d;
    logic                   rsp_valid_q, rsp_valid_d;
    cache_line_t [WAYS-1:0] rsp_lines_q, rsp_lines_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [LRU_W-1:0]       rsp_hit_way_q, rsp_hit_way_d;
    logic [LRU_W-1:0]       rsp_victim_way_q, rsp_victim_way_d;

    logic                   accept;
    logic                   wr_en;
    logic [INDEX_W-1:0]     wr_addr;
    cache_line_t [WAYS-1:0] wr_data;
    cache_line_t [WAYS-1:0] sweep_image;
    logic                   sel_hit;
    logic [LRU_W-1:0]       sel_hit_way;
    logic [LRU_W-1:0]       sel_victim_way;

    assign req_ready = (state_q == IDLE);
    assign init_busy = (state_q == SWEEP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        sweep_image = '0;
        for (int w = 0; w < WAYS; w++)
            sweep_image[w].lru = LRU_FIELD_W'(w);
    end

    // The sweep and request writes share one array write port; requests are
    // never accepted while sweeping, so the two cannot collide.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        wr_en       = 1'b0;
        wr_addr     = req_index;
        wr_data     = wr_lines;
        if (state_q == SWEEP) begin
            wr_en       = 1'b1;
            wr_addr     = sweep_idx_q;
            wr_data     = sweep_image;
            sweep_idx_d = sweep_idx_q + 1'b1;
            if (sweep_idx_q == INDEX_W'(SETS - 1))
                state_d = IDLE;
        end else if (accept && req_op == OP_WRITE) begin
            wr_en = 1'b1;
        end else if (accept && req_op == OP_CLEAR) begin
            state_d     = SWEEP;
            sweep_idx_d = '0;
        end
    end

    // Stage 1 captures the set at acceptance; stage 2 registers the
    // way_select result, so responses land one edge after acceptance.
    always_comb begin
        rd_valid_d       = accept && req_op == OP_LOOKUP;
        rd_lines_d       = rd_valid_d ? mem[req_index] : rd_lines_q;
        rd_tag_d         = rd_valid_d ? req_tag : rd_tag_q;
        rsp_valid_d      = rd_valid_q;
        rsp_lines_d      = rd_valid_q ? rd_lines_q : rsp_lines_q;
        rsp_hit_d        = rd_valid_q ? sel_hit : rsp_hit_q;
        rsp_hit_way_d    = rd_valid_q ? sel_hit_way : rsp_hit_way_q;
        rsp_victim_way_d = rd_valid_q ? sel_victim_way : rsp_victim_way_q;
    end

    way_select #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_way_select (
        .lines      (rd_lines_q),
        .tag        (rd_tag_q),
        .hit        (sel_hit),
        .hit_way    (sel_hit_way),
        .victim_way (sel_victim_way)
    );

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= SWEEP;
            sweep_idx_q      <= '0;
            rd_valid_q       <= 1'b0;
            rd_lines_q       <= '0;
            rd_tag_q         <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_lines_q      <= '0;
            rsp_hit_q        <= 1'b0;
            rsp_hit_way_q    <= '0;
            rsp_victim_way_q <= '0;
        end else begin
            state_q          <= state_d;
            sweep_idx_q      <= sweep_idx_d;
            rd_valid_q       <= rd_valid_d;
            rd_lines_q       <= rd_lines_d;
            rd_tag_q         <= rd_tag_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_lines_q      <= rsp_lines_d;
            rsp_hit_q        <= rsp_hit_d;
            rsp_hit_way_q    <= rsp_hit_way_d;
            rsp_victim_way_q <= rsp_victim_way_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_lines      = rsp_lines_q;
    assign rsp_hit        = rsp_hit_q;
    assign rsp_hit_way    = rsp_hit_way_q;
    assign rsp_victim_way = rsp_victim_way_q;

    a_req_op_known: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && req_ready) |->
            (!$isunknown(req_op) && (req_op inside {OP_LOOKUP, OP_WRITE, OP_CLEAR})));

endmodule

// File: tb/tb_cache_set_array.sv
module tb_cache_set_array;
    import my_struct_package::*;

    typedef cache_line_t [3:0] set_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    cache_op_t   req_op;
    logic [3:0]  req_index;
    logic [11:0] req_tag;
    set_t        wr_lines;
    logic        rsp_valid;
    set_t        rsp_lines;
    logic        rsp_hit;
    logic [1:0]  rsp_hit_way;
    logic [1:0]  rsp_victim_way;
    logic        init_busy;

    int n_chk  = 0;
    int n_fail = 0;

    cache_set_array #(.SETS(16), .WAYS(4), .TAG_W(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_index      (req_index),
        .req_tag        (req_tag),
        .wr_lines       (wr_lines),
        .rsp_valid      (rsp_valid),
        .rsp_lines      (rsp_lines),
        .rsp_hit        (rsp_hit),
        .rsp_hit_way    (rsp_hit_way),
        .rsp_victim_way (rsp_victim_way),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic cache_line_t mk(input logic [11:0] tg, input int lru, input mesi_t m, input logic [31:0] d);
        cache_line_t l;
        l.tag = tg;
        l.lru = LRU_FIELD_W'(lru);
        l.mesi_bits = m;
        l.data = d;
        return l;
    endfunction

    function automatic set_t init_img();
        set_t s;
        for (int w = 0; w < 4; w++) s[w] = mk(12'h0, w, MESI_I, 32'h0);
        return s;
    endfunction

    task automatic check_reset_vals(input string nm);
        chk({nm, "_init_busy"}, init_busy, 1'b1);
        chk({nm, "_req_ready"}, req_ready, 1'b0);
        chk({nm, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({nm, "_rsp_hit"}, rsp_hit, 1'b0);
        chk({nm, "_rsp_hit_way"}, rsp_hit_way, 2'd0);
        chk({nm, "_rsp_victim"}, rsp_victim_way, 2'd0);
        chk({nm, "_rsp_lines"}, rsp_lines, '0);
    endtask

    task automatic wait_sweep(input string nm);
        int cnt = 0;
        while (init_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        chk({nm, "_busy_cycles"}, cnt, 16);
        chk({nm, "_ready_after"}, req_ready, 1'b1);
    endtask

    task automatic wr(input logic [3:0] idx, input set_t lines);
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        req_index = idx;
        wr_lines  = lines;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic lookup(input string nm, input logic [3:0] idx, input logic [11:0] tg,
                          input logic hit, input logic [1:0] hw, input logic [1:0] vw);
        req_valid = 1'b1;
        req_op    = OP_LOOKUP;
        req_index = idx;
        req_tag   = tg;
        tick();
        req_valid = 1'b0;
        chk({nm, "_rsp_early"}, rsp_valid, 1'b0);
        tick();
        chk({nm, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({nm, "_hit"}, rsp_hit, hit);
        chk({nm, "_hit_way"}, rsp_hit_way, hw);
        chk({nm, "_victim"}, rsp_victim_way, vw);
        tick();
        chk({nm, "_rsp_drop"}, rsp_valid, 1'b0);
    endtask

    set_t s3, s7, s9, s10, s12;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_LOOKUP;
        req_index = '0;
        req_tag   = '0;
        wr_lines  = '0;
        #1;
        check_reset_vals("reset");
        #20;
        rst_n = 1'b1;
        wait_sweep("sweep1");

        lookup("idx5", 4'd5, 12'h000, 1'b0, 2'd0, 2'd0);
        chk("idx5_lines", rsp_lines, init_img());

        s3 = init_img();
        s3[2] = mk(12'hABC, 0, MESI_M, 32'h1234_5678);
        wr(4'd3, s3);
        lookup("idx3_abc", 4'd3, 12'hABC, 1'b1, 2'd2, 2'd0);
        chk("idx3_lines", rsp_lines, s3);
        lookup("idx3_abd", 4'd3, 12'hABD, 1'b0, 2'd0, 2'd0);
        lookup("idx3_inv_tag", 4'd3, 12'h000, 1'b0, 2'd0, 2'd0);

        s7[0] = mk(12'h010, 2, MESI_S, 32'hA0);
        s7[1] = mk(12'h011, 3, MESI_E, 32'hA1);
        s7[2] = mk(12'h012, 1, MESI_M, 32'hA2);
        s7[3] = mk(12'h013, 0, MESI_S, 32'hA3);
        wr(4'd7, s7);
        lookup("idx7", 4'd7, 12'h012, 1'b1, 2'd2, 2'd1);

        s9[0] = mk(12'h020, 0, MESI_S, 32'h0);
        s9[1] = mk(12'h021, 0, MESI_S, 32'h0);
        s9[2] = mk(12'h022, 1, MESI_S, 32'h0);
        s9[3] = mk(12'h023, 2, MESI_S, 32'h0);
        wr(4'd9, s9);
        lookup("idx9_corrupt", 4'd9, 12'h023, 1'b1, 2'd3, 2'd0);

        s10[0] = mk(12'h030, 3, MESI_M, 32'h0);
        s10[1] = mk(12'h031, 1, MESI_S, 32'h0);
        s10[2] = mk(12'h032, 2, MESI_E, 32'h0);
        s10[3] = mk(12'h033, 0, MESI_I, 32'h0);
        wr(4'd10, s10);
        lookup("idx10_inv_victim", 4'd10, 12'h033, 1'b0, 2'd0, 2'd3);

        s12 = init_img();
        s12[1] = mk(12'h055, 1, MESI_M, 32'hCAFE);
        wr(4'd12, s12);
        lookup("idx12", 4'd12, 12'h055, 1'b1, 2'd1, 2'd0);

        req_valid = 1'b1;
        req_op    = OP_LOOKUP;
        req_index = 4'd5;
        req_tag   = 12'h000;
        tick();
        req_index = 4'd3;
        req_tag   = 12'hABC;
        chk("b2b_early", rsp_valid, 1'b0);
        tick();
        chk("b2b0_valid", rsp_valid, 1'b1);
        chk("b2b0_lines", rsp_lines, init_img());
        chk("b2b0_hit", rsp_hit, 1'b0);
        req_index = 4'd7;
        req_tag   = 12'h011;
        tick();
        chk("b2b1_valid", rsp_valid, 1'b1);
        chk("b2b1_lines", rsp_lines, s3);
        chk("b2b1_hit_way", rsp_hit_way, 2'd2);
        req_index = 4'd10;
        req_tag   = 12'h030;
        tick();
        req_valid = 1'b0;
        chk("b2b2_valid", rsp_valid, 1'b1);
        chk("b2b2_lines", rsp_lines, s7);
        chk("b2b2_hit_way", rsp_hit_way, 2'd1);
        chk("b2b2_victim", rsp_victim_way, 2'd1);
        tick();
        chk("b2b3_valid", rsp_valid, 1'b1);
        chk("b2b3_lines", rsp_lines, s10);
        chk("b2b3_hit_way", rsp_hit_way, 2'd0);
        chk("b2b3_victim", rsp_victim_way, 2'd3);
        tick();
        chk("b2b_end", rsp_valid, 1'b0);

        req_valid = 1'b1;
        req_op    = OP_LOOKUP;
        req_index = 4'd7;
        req_tag   = 12'h012;
        tick();
        req_op = OP_CLEAR;
        chk("clr_lookup_early", rsp_valid, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("clr_inflight_valid", rsp_valid, 1'b1);
        chk("clr_inflight_hit", rsp_hit, 1'b1);
        chk("clr_inflight_way", rsp_hit_way, 2'd2);
        chk("clr_busy", init_busy, 1'b1);
        chk("clr_ready", req_ready, 1'b0);
        repeat (9) tick();
        chk("clr_mid_busy", init_busy, 1'b1);
        chk("clr_mid_rsp", rsp_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midsweep_reset");
        #5;
        rst_n = 1'b1;
        wait_sweep("sweep2");

        lookup("post_idx3", 4'd3, 12'hABC, 1'b0, 2'd0, 2'd0);
        chk("post_idx3_lines", rsp_lines, init_img());
        lookup("post_idx12", 4'd12, 12'h055, 1'b0, 2'd0, 2'd0);
        chk("post_idx12_lines", rsp_lines, init_img());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
